// File: rtl/rotate_engine.sv
// rotate_engine: streams a square frame from source to destination SRAM, rotated 0/90/180/270 deg clockwise.
// Optional macro ROT_CYCLE_CNT_EN adds a cycle_cnt output counting busy cycles of the last frame.
module rotate_engine #(
  parameter int IMG_SIZE = 256,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        rot_mode,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic              src_we,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              dst_en,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_wdata
`ifdef ROT_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);
  localparam int LW = $clog2(IMG_SIZE);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t          state;
  logic [1:0]      mode;
  logic [LW-1:0]   x, y, x1, y1;
  logic            v1, drain;
  logic [2*LW-1:0] nxt, dst_idx;
  always_comb nxt = {y, x} + (2*LW)'(1);
  // N-1-v in log2(N) bits is the bitwise complement of v
  always_comb dst_idx = mode == 2'd0 ? {y1, x1} :
                        mode == 2'd1 ? {x1, ~y1} :
                        mode == 2'd2 ? {~y1, ~x1} : {~x1, y1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= '0;
      x         <= '0;
      y         <= '0;
      x1        <= '0;
      y1        <= '0;
      v1        <= 1'b0;
      drain     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      src_en    <= 1'b0;
      src_we    <= 1'b0;
      src_addr  <= '0;
      dst_en    <= 1'b0;
      dst_we    <= 1'b0;
      dst_addr  <= '0;
      dst_wdata <= '0;
    end else begin
      v1     <= 1'b0;
      done   <= 1'b0;
      src_we <= 1'b0;
      dst_en <= v1;
      dst_we <= v1;
      if (v1) begin
        dst_addr  <= ADDR_W'(dst_idx);
        dst_wdata <= src_rdata;
      end
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          mode     <= rot_mode;
          x        <= '0;
          y        <= '0;
          busy     <= 1'b1;
          src_en   <= 1'b1;
          src_addr <= '0;
        end
        RUN: begin
          v1       <= 1'b1;
          x1       <= x;
          y1       <= y;
          x        <= nxt[LW-1:0];
          y        <= nxt[2*LW-1:LW];
          src_addr <= ADDR_W'(nxt);
          if (&{y, x}) begin
            state  <= DRAIN;
            src_en <= 1'b0;
            drain  <= 1'b0;
          end
        end
        DRAIN: begin
          drain <= 1'b1;
          if (drain) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ROT_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cycle_cnt <= '0;
    else if (state == IDLE && start) cycle_cnt <= '0;
    else if (busy) cycle_cnt <= cycle_cnt + 32'd1;
`endif
endmodule
